cursor_report_integrator: RTL and testbench

//  Downstream consumer of the intent-gated dx/dy stream. Integrates gated deltas

---
 rtl/cursor_pkg.sv | 32 +++
 rtl/cursor_report_integrator_axis.sv | 81 ++++++++
 rtl/cursor_report_integrator.sv | 125 ++++++++++++
 tb/tb_cursor_report_integrator.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cursor_pkg.sv
// Shared constants, FSM state type and saturating-add helper for the cursor
// report integrator.
package cursor_pkg;

    localparam int REP_MAX = 127;
    localparam int DELTA_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Symmetric saturation to +/-(2**(width-1)-1); the most negative code is never produced.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 width
    );
        logic signed [31:0] lim;
        logic signed [31:0] sum;
        lim = (32'sd1 <<< (width - 1)) - 32'sd1;
        sum = a + b;
        if (sum > lim) begin
            return lim;
        end
        if (sum < -lim) begin
            return -lim;
        end
        return sum;
    endfunction

endpackage

// File: rtl/cursor_report_integrator_axis.sv
// One axis of the cursor: clamped absolute position plus the saturating
// residual accumulator that feeds relative reports.
module axis_clamp_integrator
    import cursor_pkg::*;
#(
    parameter int LIMIT = 1920,
    parameter int POS_W = 12,
    parameter int ACC_W = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sample_en,
    input  logic signed [DELTA_W-1:0] delta,
    input  logic                      recenter,
    input  logic                      consume,
    output logic [POS_W-1:0]          pos,
    output logic signed [DELTA_W-1:0] rep_val,
    output logic                      nonzero,
    output logic                      sat_hit
);

    localparam logic [POS_W-1:0] CENTER  = POS_W'(LIMIT / 2);
    localparam logic signed [31:0] ACC_LIM = (32'sd1 <<< (ACC_W - 1)) - 32'sd1;

    logic [POS_W-1:0]         pos_q, pos_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [31:0]       acc_ext;
    logic signed [31:0]       pos_sum;
    logic signed [31:0]       acc_base;
    logic signed [31:0]       acc_add;
    logic signed [31:0]       acc_raw;

    always_comb begin
        acc_ext = 32'(acc_q);
        if (acc_ext > 32'(REP_MAX)) begin
            rep_val = DELTA_W'(REP_MAX);
        end else if (acc_ext < -32'(REP_MAX)) begin
            rep_val = DELTA_W'(-REP_MAX);
        end else begin
            rep_val = DELTA_W'(acc_ext);
        end
    end

    // A launch removes exactly what was emitted before this cycle's delta is added.
    always_comb begin
        pos_sum  = $signed(32'(pos_q)) + 32'(delta);
        acc_base = 32'(acc_q) - (consume ? 32'(rep_val) : 32'sd0);
        acc_add  = sample_en ? 32'(delta) : 32'sd0;
        acc_raw  = acc_base + acc_add;
        pos_d    = pos_q;
        acc_d    = ACC_W'(sat_add(acc_base, acc_add, ACC_W));
        sat_hit  = (acc_raw > ACC_LIM) || (acc_raw < -ACC_LIM);
        if (recenter) begin
            pos_d   = CENTER;
            acc_d   = '0;
            sat_hit = 1'b0;
        end else if (sample_en) begin
            if (pos_sum < 0) begin
                pos_d = '0;
            end else if (pos_sum > LIMIT - 1) begin
                pos_d = POS_W'(LIMIT - 1);
            end else begin
                pos_d = POS_W'(pos_sum);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= CENTER;
            acc_q <= '0;
        end else begin
            pos_q <= pos_d;
            acc_q <= acc_d;
        end
    end

    assign pos     = pos_q;
    assign nonzero = (acc_q != '0);

endmodule

// File: rtl/cursor_report_integrator.sv
// Integrates gated dx/dy into an absolute cursor and emits rate-limited
// relative reports over a valid/ready handshake.
module cursor_report_integrator
    import cursor_pkg::*;
#(
    parameter int SCR_W      = 1920,
    parameter int SCR_H      = 1080,
    parameter int POS_W      = 12,
    parameter int ACC_W      = 12,
    parameter int REPORT_DIV = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sample_en,
    input  logic signed [DELTA_W-1:0] dx_in,
    input  logic signed [DELTA_W-1:0] dy_in,
    input  logic                      btn_in,
    input  logic                      recenter,
    output logic [POS_W-1:0]          pos_x,
    output logic [POS_W-1:0]          pos_y,
    output logic                      rep_valid,
    input  logic                      rep_ready,
    output logic signed [DELTA_W-1:0] rep_dx,
    output logic signed [DELTA_W-1:0] rep_dy,
    output logic                      rep_btn,
    output logic                      acc_sat
);

    localparam int CNT_W = (REPORT_DIV > 1) ? $clog2(REPORT_DIV) : 1;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      pending_q, pending_d;
    logic                      btn_lat_q, btn_lat_d;
    logic signed [DELTA_W-1:0] rep_dx_q, rep_dx_d;
    logic signed [DELTA_W-1:0] rep_dy_q, rep_dy_d;
    logic                      rep_btn_q, rep_btn_d;
    logic                      acc_sat_q, acc_sat_d;

    logic                      wrap, idle_pend, launch;
    logic                      nz_x, nz_y, sat_x, sat_y;
    logic signed [DELTA_W-1:0] val_x, val_y;

    axis_clamp_integrator #(.LIMIT(SCR_W), .POS_W(POS_W), .ACC_W(ACC_W)) u_axis_x (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .delta(dx_in),
        .recenter(recenter), .consume(launch), .pos(pos_x), .rep_val(val_x),
        .nonzero(nz_x), .sat_hit(sat_x)
    );

    axis_clamp_integrator #(.LIMIT(SCR_H), .POS_W(POS_W), .ACC_W(ACC_W)) u_axis_y (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .delta(dy_in),
        .recenter(recenter), .consume(launch), .pos(pos_y), .rep_val(val_y),
        .nonzero(nz_y), .sat_hit(sat_y)
    );

    // Recenter suppresses any launch; a report already held is left alone.
    always_comb begin
        wrap      = sample_en && !recenter && (cnt_q == CNT_W'(REPORT_DIV - 1));
        idle_pend = (state_q == IDLE) && pending_q && !recenter;
        launch    = idle_pend && (nz_x || nz_y || (btn_lat_q != rep_btn_q));

        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        btn_lat_d = sample_en ? btn_in : btn_lat_q;
        rep_dx_d  = rep_dx_q;
        rep_dy_d  = rep_dy_q;
        rep_btn_d = rep_btn_q;
        acc_sat_d = acc_sat_q | sat_x | sat_y;

        if (launch) begin
            state_d   = HOLD;
            rep_dx_d  = val_x;
            rep_dy_d  = val_y;
            rep_btn_d = btn_lat_q;
        end else if ((state_q == HOLD) && rep_ready) begin
            state_d = IDLE;
        end

        if (idle_pend) begin
            pending_d = 1'b0;
        end
        if (wrap) begin
            pending_d = 1'b1;
            cnt_d     = '0;
        end else if (sample_en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (recenter) begin
            cnt_d     = '0;
            pending_d = 1'b0;
            acc_sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            btn_lat_q <= 1'b0;
            rep_dx_q  <= '0;
            rep_dy_q  <= '0;
            rep_btn_q <= 1'b0;
            acc_sat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            btn_lat_q <= btn_lat_d;
            rep_dx_q  <= rep_dx_d;
            rep_dy_q  <= rep_dy_d;
            rep_btn_q <= rep_btn_d;
            acc_sat_q <= acc_sat_d;
        end
    end

    assign rep_valid = (state_q == HOLD);
    assign rep_dx    = rep_dx_q;
    assign rep_dy    = rep_dy_q;
    assign rep_btn   = rep_btn_q;
    assign acc_sat   = acc_sat_q;

endmodule

// File: tb/tb_cursor_report_integrator.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a behavioural model.
module tb_cursor_report_integrator;

    localparam int SCR_W      = 1920;
    localparam int SCR_H      = 1080;
    localparam int REPORT_DIV = 4;
    localparam int ACC_MAX    = 2047;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sample_en = 1'b0;
    logic signed [7:0] dx_in = '0;
    logic signed [7:0] dy_in = '0;
    logic              btn_in = 1'b0;
    logic              recenter = 1'b0;
    logic              rep_ready = 1'b0;
    logic [11:0]       pos_x, pos_y;
    logic              rep_valid;
    logic signed [7:0] rep_dx, rep_dy;
    logic              rep_btn;
    logic              acc_sat;

    int vectors = 0;
    int miscompares = 0;

    int mPosX, mPosY, mAccX, mAccY, mCnt, mRepDx, mRepDy;
    bit mPend, mHold, mBtnLat, mRepBtn, mSat;

    cursor_report_integrator #(
        .SCR_W(SCR_W), .SCR_H(SCR_H), .POS_W(12), .ACC_W(12), .REPORT_DIV(REPORT_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .dx_in(dx_in), .dy_in(dy_in),
        .btn_in(btn_in), .recenter(recenter), .pos_x(pos_x), .pos_y(pos_y),
        .rep_valid(rep_valid), .rep_ready(rep_ready), .rep_dx(rep_dx), .rep_dy(rep_dy),
        .rep_btn(rep_btn), .acc_sat(acc_sat)
    );

    always #5 clk = ~clk;

    function automatic int clampI(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic modelReset();
        mPosX = SCR_W / 2; mPosY = SCR_H / 2;
        mAccX = 0; mAccY = 0; mCnt = 0; mRepDx = 0; mRepDy = 0;
        mPend = 0; mHold = 0; mBtnLat = 0; mRepBtn = 0; mSat = 0;
    endtask

    // Reference behaviour for one clock edge, from the rules of the block.
    task automatic modelStep();
        int dxv, dyv, ex, ey, nx, ny;
        bit idlePend, doLaunch;
        dxv = sample_en ? int'(dx_in) : 0;
        dyv = sample_en ? int'(dy_in) : 0;
        if (recenter) begin
            if (mHold && rep_ready) mHold = 0;
            mPosX = SCR_W / 2; mPosY = SCR_H / 2;
            mAccX = 0; mAccY = 0; mSat = 0; mPend = 0; mCnt = 0;
        end else begin
            idlePend = !mHold && mPend;
            doLaunch = idlePend && (mAccX != 0 || mAccY != 0 || mBtnLat != mRepBtn);
            ex = 0; ey = 0;
            if (doLaunch) begin
                ex = clampI(mAccX, -127, 127);
                ey = clampI(mAccY, -127, 127);
                mRepDx = ex; mRepDy = ey; mRepBtn = mBtnLat; mHold = 1;
            end else if (mHold && rep_ready) begin
                mHold = 0;
            end
            nx = mAccX - ex + dxv;
            ny = mAccY - ey + dyv;
            if (nx > ACC_MAX || nx < -ACC_MAX || ny > ACC_MAX || ny < -ACC_MAX) mSat = 1;
            mAccX = clampI(nx, -ACC_MAX, ACC_MAX);
            mAccY = clampI(ny, -ACC_MAX, ACC_MAX);
            if (sample_en) begin
                mPosX = clampI(mPosX + dxv, 0, SCR_W - 1);
                mPosY = clampI(mPosY + dyv, 0, SCR_H - 1);
                mCnt++;
            end
            if (idlePend) mPend = 0;
            if (mCnt == REPORT_DIV) begin
                mCnt = 0;
                mPend = 1;
            end
        end
        if (sample_en) mBtnLat = btn_in;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) modelReset();
        else modelStep();
    end

    task automatic checkVal(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkVal("pos_x", int'(pos_x), mPosX);
        checkVal("pos_y", int'(pos_y), mPosY);
        checkVal("rep_valid", int'(rep_valid), int'(mHold));
        checkVal("rep_dx", int'(rep_dx), mRepDx);
        checkVal("rep_dy", int'(rep_dy), mRepDy);
        checkVal("rep_btn", int'(rep_btn), int'(mRepBtn));
        checkVal("acc_sat", int'(acc_sat), int'(mSat));
    endtask

    always @(negedge clk) begin
        if (rst_n) checkOutput();
    end

    // Inputs are set at a falling edge and held for exactly one rising edge.
    task automatic applyStimulus(input bit se, input int dx, input int dy,
                                 input bit btn, input bit rc, input bit rdy);
        sample_en = se;
        dx_in     = 8'(dx);
        dy_in     = 8'(dy);
        btn_in    = btn;
        recenter  = rc;
        rep_ready = rdy;
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        sample_en = 1'b0; dx_in = '0; dy_in = '0; btn_in = 1'b0;
        recenter = 1'b0; rep_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int dx, dy;
        bit se, rdy, rc, btn, bias;
        @(negedge clk);
        doReset();

        // Reset values and first sample
        checkVal("reset pos_x", int'(pos_x), 960);
        checkVal("reset pos_y", int'(pos_y), 540);
        checkVal("reset rep_valid", int'(rep_valid), 0);
        checkVal("reset acc_sat", int'(acc_sat), 0);
        applyStimulus(1, 5, -3, 0, 0, 1);
        checkVal("t1 pos_x", int'(pos_x), 965);
        checkVal("t1 pos_y", int'(pos_y), 537);
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkVal("t1 no early report", int'(rep_valid), 0);

        // Residual drains over two reports
        doReset();
        repeat (4) applyStimulus(1, 40, 0, 0, 0, 1);
        checkVal("t2 no report yet", int'(rep_valid), 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkVal("t2 first valid", int'(rep_valid), 1);
        checkVal("t2 first dx", int'(rep_dx), 127);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkVal("t2 valid drops", int'(rep_valid), 0);
        repeat (4) applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkVal("t2 second valid", int'(rep_valid), 1);
        checkVal("t2 second dx", int'(rep_dx), 33);
        applyStimulus(0, 0, 0, 0, 0, 1);
        repeat (4) applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkVal("t2 acc drained", int'(rep_valid), 0);

        // Position clamps at both screen edges
        doReset();
        repeat (7) applyStimulus(1, 127, 0, 0, 0, 1);
        applyStimulus(1, 66, 0, 0, 0, 1);
        checkVal("t3 pos 1915", int'(pos_x), 1915);
        applyStimulus(1, 20, 0, 0, 0, 1);
        checkVal("t3 clamp high", int'(pos_x), 1919);
        repeat (15) applyStimulus(1, -127, 0, 0, 0, 1);
        applyStimulus(1, -11, 0, 0, 0, 1);
        checkVal("t3 pos 3", int'(pos_x), 3);
        applyStimulus(1, -10, 0, 0, 0, 1);
        checkVal("t3 clamp low", int'(pos_x), 0);

        // Backpressure holds the payload while motion keeps accumulating
        doReset();
        repeat (4) applyStimulus(1, 10, 0, 0, 0, 0);
        repeat (20) applyStimulus(1, 3, 0, 0, 0, 0);
        checkVal("t4 held valid", int'(rep_valid), 1);
        checkVal("t4 held dx", int'(rep_dx), 40);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkVal("t4 handshake", int'(rep_valid), 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkVal("t4 next valid", int'(rep_valid), 1);
        checkVal("t4 next dx", int'(rep_dx), 60);
        applyStimulus(0, 0, 0, 0, 0, 1);

        // Button change alone produces a report
        doReset();
        repeat (4) applyStimulus(1, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 1);
        checkVal("t5 valid", int'(rep_valid), 1);
        checkVal("t5 dx", int'(rep_dx), 0);
        checkVal("t5 dy", int'(rep_dy), 0);
        checkVal("t5 btn", int'(rep_btn), 1);
        applyStimulus(0, 0, 0, 1, 0, 1);

        // Saturation, then recenter during a held report
        doReset();
        repeat (40) applyStimulus(1, 127, 0, 0, 0, 0);
        checkVal("t6 sat set", int'(acc_sat), 1);
        applyStimulus(1, 5, 5, 0, 1, 0);
        checkVal("t6 pos_x center", int'(pos_x), 960);
        checkVal("t6 pos_y center", int'(pos_y), 540);
        checkVal("t6 sat cleared", int'(acc_sat), 0);
        checkVal("t6 held valid", int'(rep_valid), 1);
        checkVal("t6 held dx", int'(rep_dx), 127);
        applyStimulus(0, 0, 0, 0, 0, 1);
        repeat (4) applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkVal("t6 acc cleared", int'(rep_valid), 0);

        // Asynchronous reset while a report is held
        repeat (4) applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkVal("async pre valid", int'(rep_valid), 1);
        #2 rst_n = 1'b0;
        #1 checkVal("async drop", int'(rep_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic with biased phases to reach saturation and edges
        bias = 0;
        btn = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) bias = ($urandom_range(0, 1) == 1);
            se = ($urandom_range(0, 2) != 0);
            if (bias) begin
                dx = ((i / 200) % 2 == 0) ? int'($urandom_range(100, 127)) : -int'($urandom_range(100, 127));
                dy = ((i / 400) % 2 == 0) ? int'($urandom_range(90, 127)) : -int'($urandom_range(90, 127));
                rdy = ($urandom_range(0, 9) == 0);
            end else begin
                dx = int'($urandom_range(0, 254)) - 127;
                dy = int'($urandom_range(0, 254)) - 127;
                rdy = ($urandom_range(0, 2) != 0);
            end
            if ($urandom_range(0, 19) == 0) btn = ~btn;
            rc = ($urandom_range(0, 149) == 0);
            applyStimulus(se, dx, dy, btn, rc, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
